// File: rtl/sram_dpram_block_fetcher_pkg.sv
// Shared types and widths for the SRAM -> DP-RAM 8x8 block fetcher.
package sram_dpram_block_fetcher_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam int DP_AW   = 7;
  localparam int DP_DW   = 32;
  localparam int ELEM_W  = 6;

  typedef enum logic [1:0] {
    S_FS_IDLE,
    S_FS_ISSUE,
    S_FS_DRAIN,
    S_FS_DONE
  } fetch_state_type;

  typedef logic [ELEM_W-1:0] elem_idx_t;

  function automatic logic is_last_elem(input elem_idx_t n);
    return n == {ELEM_W{1'b1}};
  endfunction

endpackage

// File: rtl/sram_dpram_block_fetcher_if.sv
// Handshake, SRAM read port and DP-RAM write port of the block fetcher.
interface sram_dpram_block_fetcher_if;
  import sram_dpram_block_fetcher_pkg::*;

  logic               start;
  logic               busy;
  logic               done;
  logic               plane_done;
  logic [SRAM_AW-1:0] SRAM_address;
  logic [SRAM_DW-1:0] SRAM_read_data;
  logic [DP_AW-1:0]   DP_RAM_Address;
  logic [DP_DW-1:0]   DP_RAM_Write_Data;
  logic               DP_RAM_we;

  modport master (
    output start, SRAM_read_data,
    input  busy, done, plane_done, SRAM_address,
    input  DP_RAM_Address, DP_RAM_Write_Data, DP_RAM_we
  );

  modport slave (
    input  start, SRAM_read_data,
    output busy, done, plane_done, SRAM_address,
    output DP_RAM_Address, DP_RAM_Write_Data, DP_RAM_we
  );

endinterface

// File: rtl/sram_dpram_block_fetcher_addr_gen.sv
// Block position counters and raster SRAM address walk inside one 8x8 block.
module sram_block_addr_gen
  import sram_dpram_block_fetcher_pkg::*;
#(
  parameter logic [SRAM_AW-1:0] SRAM_BASE  = 18'd0,
  parameter int                 ROW_STRIDE = 320,
  parameter int                 BLOCK_COLS = 40,
  parameter int                 BLOCK_ROWS = 30
) (
  input  logic               Clock_50,
  input  logic               reset,
  input  logic               load,
  input  logic               advance,
  input  logic               next_block,
  output elem_idx_t          elem_idx,
  output logic               last_block,
  output logic [SRAM_AW-1:0] SRAM_address
);

  localparam int COL_W = (BLOCK_COLS > 1) ? $clog2(BLOCK_COLS) : 1;
  localparam int ROW_W = (BLOCK_ROWS > 1) ? $clog2(BLOCK_ROWS) : 1;
  localparam logic [SRAM_AW-1:0] STRIDE       = SRAM_AW'(ROW_STRIDE);
  localparam logic [SRAM_AW-1:0] BLOCK_STRIDE = SRAM_AW'(8 * ROW_STRIDE);

  logic [COL_W-1:0]   block_col;
  logic [ROW_W-1:0]   block_row;
  logic [SRAM_AW-1:0] block_origin;
  logic [SRAM_AW-1:0] block_row_origin;
  logic [SRAM_AW-1:0] row_base;

  assign last_block = (block_col == COL_W'(BLOCK_COLS - 1)) &&
                      (block_row == ROW_W'(BLOCK_ROWS - 1));

  // Origins are kept as running sums so no multiplier is needed.
  always_ff @(posedge Clock_50 or posedge reset) begin
    if (reset) begin
      block_col        <= '0;
      block_row        <= '0;
      block_origin     <= SRAM_BASE;
      block_row_origin <= SRAM_BASE;
    end else if (next_block) begin
      if (block_col == COL_W'(BLOCK_COLS - 1)) begin
        block_col <= '0;
        if (block_row == ROW_W'(BLOCK_ROWS - 1)) begin
          block_row        <= '0;
          block_origin     <= SRAM_BASE;
          block_row_origin <= SRAM_BASE;
        end else begin
          block_row        <= block_row + ROW_W'(1);
          block_origin     <= block_row_origin + BLOCK_STRIDE;
          block_row_origin <= block_row_origin + BLOCK_STRIDE;
        end
      end else begin
        block_col    <= block_col + COL_W'(1);
        block_origin <= block_origin + SRAM_AW'(8);
      end
    end
  end

  always_ff @(posedge Clock_50 or posedge reset) begin
    if (reset) begin
      row_base     <= SRAM_BASE;
      SRAM_address <= SRAM_BASE;
      elem_idx     <= '0;
    end else if (load) begin
      row_base     <= block_origin;
      SRAM_address <= block_origin;
      elem_idx     <= '0;
    end else if (advance) begin
      elem_idx <= elem_idx + ELEM_W'(1);
      if (elem_idx[2:0] == 3'd7) begin
        row_base     <= row_base + STRIDE;
        SRAM_address <= row_base + STRIDE;
      end else begin
        SRAM_address <= SRAM_address + SRAM_AW'(1);
      end
    end
  end

endmodule

// File: rtl/sram_dpram_block_fetcher.sv
// Fetches one 8x8 block of 16-bit SRAM samples and packs sample pairs into 32 DP-RAM words.
module sram_dpram_block_fetcher
  import sram_dpram_block_fetcher_pkg::*;
#(
  parameter logic [SRAM_AW-1:0] SRAM_BASE    = 18'd0,
  parameter int                 ROW_STRIDE   = 320,
  parameter int                 BLOCK_COLS   = 40,
  parameter int                 BLOCK_ROWS   = 30,
  parameter logic [DP_AW-1:0]   DP_BASE      = 7'd0,
  parameter int                 SRAM_LATENCY = 3
) (
  input  logic                        Clock_50,
  input  logic                        reset,
  sram_dpram_block_fetcher_if.slave   bus
);

  fetch_state_type state, state_next;

  logic      load, advance, next_block, last_block;
  elem_idx_t elem_idx;

  logic [SRAM_LATENCY-1:0] pipe_valid;
  elem_idx_t               pipe_idx [SRAM_LATENCY];
  logic                    cap_valid;
  elem_idx_t               cap_idx;

  logic [SRAM_DW-1:0] hold;
  logic [DP_AW-1:0]   dp_addr;
  logic [DP_DW-1:0]   dp_data;
  logic               dp_we;

  sram_block_addr_gen #(
    .SRAM_BASE  (SRAM_BASE),
    .ROW_STRIDE (ROW_STRIDE),
    .BLOCK_COLS (BLOCK_COLS),
    .BLOCK_ROWS (BLOCK_ROWS)
  ) u_addr_gen (
    .Clock_50     (Clock_50),
    .reset        (reset),
    .load         (load),
    .advance      (advance),
    .next_block   (next_block),
    .elem_idx     (elem_idx),
    .last_block   (last_block),
    .SRAM_address (bus.SRAM_address)
  );

  always_ff @(posedge Clock_50 or posedge reset) begin
    if (reset) state <= S_FS_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load           = 1'b0;
    advance        = 1'b0;
    next_block     = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.plane_done = 1'b0;
    case (state)
      S_FS_IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = S_FS_ISSUE;
        end
      end
      S_FS_ISSUE: begin
        bus.busy = 1'b1;
        advance  = 1'b1;
        if (is_last_elem(elem_idx)) state_next = S_FS_DRAIN;
      end
      S_FS_DRAIN: begin
        bus.busy = 1'b1;
        if (pipe_valid == '0) state_next = S_FS_DONE;
      end
      S_FS_DONE: begin
        bus.done       = 1'b1;
        bus.plane_done = last_block;
        next_block     = 1'b1;
        state_next     = S_FS_IDLE;
      end
      default: state_next = S_FS_IDLE;
    endcase
  end

  // A tag enters while its address is on the bus and leaves when the SRAM data is valid.
  always_ff @(posedge Clock_50 or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < SRAM_LATENCY; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_valid[0] <= advance;
      pipe_idx[0]   <= elem_idx;
      for (int i = 1; i < SRAM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_idx[i]   <= pipe_idx[i-1];
      end
    end
  end

  assign cap_valid = pipe_valid[SRAM_LATENCY-1];
  assign cap_idx   = pipe_idx[SRAM_LATENCY-1];

  always_ff @(posedge Clock_50 or posedge reset) begin
    if (reset) begin
      hold    <= '0;
      dp_addr <= DP_BASE;
      dp_data <= '0;
      dp_we   <= 1'b0;
    end else begin
      dp_we <= 1'b0;
      if (cap_valid) begin
        if (!cap_idx[0]) begin
          hold <= bus.SRAM_read_data;
        end else begin
          dp_data <= {hold, bus.SRAM_read_data};
          dp_addr <= DP_BASE + DP_AW'(cap_idx[ELEM_W-1:1]);
          dp_we   <= 1'b1;
        end
      end
    end
  end

  assign bus.DP_RAM_Address    = dp_addr;
  assign bus.DP_RAM_Write_Data = dp_data;
  assign bus.DP_RAM_we         = dp_we;

endmodule

// File: tb/tb_sram_dpram_block_fetcher.sv
// Scoreboard bench: a 3-cycle SRAM returning address[15:0], expected DP-RAM writes queued per fetch.
module tb_sram_dpram_block_fetcher;
  import sram_dpram_block_fetcher_pkg::*;

  localparam int ROW_STRIDE  = 320;
  localparam int BLOCK_COLS  = 40;
  localparam int BLOCK_ROWS  = 30;
  localparam int LATENCY     = 69;
  localparam int BUSY_CYCLES = 68;

  typedef struct packed {
    logic [DP_AW-1:0] addr;
    logic [DP_DW-1:0] data;
  } dp_write_t;

  logic Clock_50 = 1'b0;
  logic reset    = 1'b1;

  logic [SRAM_AW-1:0] sram_a1 = '0;
  logic [SRAM_AW-1:0] sram_a2 = '0;
  logic [SRAM_AW-1:0] sram_a3 = '0;

  dp_write_t exp_q [$];
  int tests_run    = 0;
  int tests_failed = 0;
  int tb_col       = 0;
  int tb_row       = 0;

  sram_dpram_block_fetcher_if bus ();

  sram_dpram_block_fetcher dut (
    .Clock_50 (Clock_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 Clock_50 = ~Clock_50;

  always @(posedge Clock_50) begin
    sram_a1 <= bus.SRAM_address;
    sram_a2 <= sram_a1;
    sram_a3 <= sram_a2;
  end
  assign bus.SRAM_read_data = sram_a3[15:0];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  always @(negedge Clock_50) begin : write_monitor
    dp_write_t e;
    if (!reset && bus.DP_RAM_we) begin
      if (exp_q.size() == 0) begin
        checkOutput("extra_write", bus.DP_RAM_we, 1'b0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("dp_addr", bus.DP_RAM_Address, e.addr);
        checkOutput("dp_data", bus.DP_RAM_Write_Data, e.data);
      end
    end
  end

  task automatic pushBlock(input int bc, input int br);
    dp_write_t        e;
    logic [SRAM_AW-1:0] a;
    for (int p = 0; p < 32; p++) begin
      a      = SRAM_AW'(br * 8 * ROW_STRIDE + bc * 8 + (p / 4) * ROW_STRIDE + (p % 4) * 2);
      e.addr = DP_AW'(p);
      e.data = {a[15:0], a[15:0] + 16'd1};
      exp_q.push_back(e);
    end
  endtask

  task automatic advanceModel();
    tb_col++;
    if (tb_col == BLOCK_COLS) begin
      tb_col = 0;
      tb_row++;
      if (tb_row == BLOCK_ROWS) tb_row = 0;
    end
  endtask

  // One complete fetch; pulse_at re-asserts start in that cycle of the active fetch.
  task automatic applyStimulus(input int pulse_at);
    int   cyc;
    int   busy_cnt;
    logic got_done;
    logic exp_plane;
    exp_plane = (tb_row == BLOCK_ROWS - 1) && (tb_col == BLOCK_COLS - 1);
    pushBlock(tb_col, tb_row);
    @(negedge Clock_50);
    checkOutput("done_idle", bus.done, 1'b0);
    bus.start = 1'b1;
    @(negedge Clock_50);
    bus.start = 1'b0;
    cyc       = 1;
    busy_cnt  = 0;
    got_done  = 1'b0;
    while (!got_done && cyc <= 200) begin
      bus.start = (cyc == pulse_at);
      if (bus.done) begin
        got_done = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        @(negedge Clock_50);
        cyc++;
      end
    end
    bus.start = 1'b0;
    checkOutput("done_seen", got_done, 1'b1);
    checkOutput("done_latency", cyc, LATENCY);
    checkOutput("busy_cycles", busy_cnt, BUSY_CYCLES);
    checkOutput("busy_at_done", bus.busy, 1'b0);
    checkOutput("plane_done", bus.plane_done, exp_plane);
    checkOutput("writes_pending", exp_q.size(), 0);
    advanceModel();
  endtask

  initial begin
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge Clock_50);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_done", bus.done, 1'b0);
    checkOutput("rst_plane_done", bus.plane_done, 1'b0);
    checkOutput("rst_we", bus.DP_RAM_we, 1'b0);
    checkOutput("rst_sram_addr", bus.SRAM_address, 18'd0);
    checkOutput("rst_dp_addr", bus.DP_RAM_Address, 7'd0);
    checkOutput("rst_dp_data", bus.DP_RAM_Write_Data, 32'd0);
    reset = 1'b0;

    applyStimulus(0);
    applyStimulus(10);
    for (int i = 3; i <= 1201; i++) applyStimulus(0);

    pushBlock(tb_col, tb_row);
    @(negedge Clock_50);
    bus.start = 1'b1;
    @(negedge Clock_50);
    bus.start = 1'b0;
    repeat (29) @(negedge Clock_50);
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", bus.busy, 1'b0);
    checkOutput("abort_done", bus.done, 1'b0);
    checkOutput("abort_plane_done", bus.plane_done, 1'b0);
    checkOutput("abort_we", bus.DP_RAM_we, 1'b0);
    checkOutput("abort_sram_addr", bus.SRAM_address, 18'd0);
    checkOutput("abort_dp_addr", bus.DP_RAM_Address, 7'd0);
    checkOutput("abort_dp_data", bus.DP_RAM_Write_Data, 32'd0);
    exp_q.delete();
    tb_col = 0;
    tb_row = 0;
    @(negedge Clock_50);
    reset = 1'b0;
    applyStimulus(0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
